// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads over a req/ack handshake, owns the PC,
// applies jump/branch redirects and substitutes a NOP when memory fails to answer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_stage,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] fetch_addr;
  logic [31:0] next_pc;
  logic [31:0] redir_addr;
  logic        redirect_pend;
  logic [7:0]  wait_cnt;
  logic        fetch_start;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  assign fetch_start = (state == IDLE) && fetch_stage;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      fetch_addr    <= RESET_PC;
      next_pc       <= RESET_PC;
      redir_addr    <= RESET_PC;
      redirect_pend <= 1'b0;
      wait_cnt      <= 8'd0;
      instr         <= NOP_INSTR;
      pc            <= RESET_PC;
      fetch_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_stage) begin
            // A redirect arriving on this very cycle takes precedence over a stored one.
            if (pc_load)            fetch_addr <= word_align(pc_target);
            else if (redirect_pend) fetch_addr <= redir_addr;
            else                    fetch_addr <= next_pc;
            state <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_ack) begin
            instr   <= mem_rdata;
            pc      <= fetch_addr;
            next_pc <= fetch_addr + 32'd4;
            state   <= DONE;
          end else if (wait_cnt >= TIMEOUT_LAST) begin
            instr     <= NOP_INSTR;
            pc        <= fetch_addr;
            next_pc   <= fetch_addr + 32'd4;
            fetch_err <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fetch_start) redirect_pend <= 1'b0;
      if (pc_load) begin
        if (pc_target[1:0] != 2'b00) fetch_err <= 1'b1;
        if (!fetch_start) begin
          redir_addr    <= word_align(pc_target);
          redirect_pend <= 1'b1;
        end
      end
    end
  end

  assign mem_req     = (state == REQ) || (state == WAIT);
  assign mem_addr    = fetch_addr;
  assign instr_valid = (state == DONE);
  assign pc_plus4    = pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          TIMEOUT   = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        fetch_stage;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_stage(fetch_stage),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks on the chosen WAIT cycle (req cycle 1 is the REQ cycle).
  int   ack_delay = 1;
  int   cur_delay = 1;
  int   req_cyc   = 0;
  bit   rand_mode = 0;
  bit   stray_ack = 0;
  logic [31:0] rdata_val = 32'h0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (mem_req) begin
      req_cyc = req_cyc + 1;
      if (req_cyc == 1) cur_delay = rand_mode ? int'($urandom_range(1, 20)) : ack_delay;
      mem_ack = stray_ack || (cur_delay > 0 && req_cyc == cur_delay + 1) ||
                (rand_mode && req_cyc == 1 && ($urandom % 4 == 0));
    end else begin
      req_cyc = 0;
      mem_ack = stray_ack || (rand_mode && ($urandom % 8 == 0));
    end
    mem_rdata = rand_mode ? $urandom : rdata_val;
  end

  // Transaction-level model: a request is outstanding from issue until answered or
  // given up after TIMEOUT waiting cycles; the cycle after completion shows the result.
  logic        m_req, m_first, m_vld, m_pend, m_err;
  int          m_waits;
  logic [31:0] m_addr, m_next, m_redir, m_instr, m_pc, m_tgt;
  bit          m_took;

  always @(posedge clk) begin
    m_tgt  = pc_target & 32'hFFFF_FFFC;
    m_took = 0;
    if (!rst) begin
      m_req = 0; m_first = 0; m_vld = 0; m_pend = 0; m_err = 0; m_waits = 0;
      m_addr = RESET_PC; m_next = RESET_PC; m_redir = RESET_PC;
      m_instr = NOP_INSTR; m_pc = RESET_PC;
    end else begin
      if (m_vld) begin
        m_vld = 0;
      end else if (m_req) begin
        if (m_first) begin
          m_first = 0;
        end else begin
          m_waits = m_waits + 1;
          if (mem_ack || m_waits >= TIMEOUT) begin
            m_instr = mem_ack ? mem_rdata : NOP_INSTR;
            if (!mem_ack) m_err = 1;
            m_pc   = m_addr;
            m_next = m_addr + 32'd4;
            m_req  = 0;
            m_vld  = 1;
          end
        end
      end else if (fetch_stage) begin
        m_req = 1; m_first = 1; m_waits = 0;
        if (pc_load) begin
          m_addr = m_tgt;
          m_took = 1;
        end else begin
          m_addr = m_pend ? m_redir : m_next;
        end
        m_pend = 0;
      end
      if (pc_load) begin
        if (pc_target[1:0] != 2'b00) m_err = 1;
        if (!m_took) begin
          m_redir = m_tgt;
          m_pend  = 1;
        end
      end
    end
    #2;
    chk("mem_req",     32'(mem_req),     32'(m_req));
    chk("mem_addr",    mem_addr,         m_addr);
    chk("instr",       instr,            m_instr);
    chk("instr_valid", 32'(instr_valid), 32'(m_vld));
    chk("pc",          pc,               m_pc);
    chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
    chk("fetch_err",   32'(fetch_err),   32'(m_err));
  end

  // One fetch: load_at = 0 pulses pc_load with fetch_stage, >0 on that cycle after, <0 never.
  task automatic do_fetch(input int load_at, input logic [31:0] tgt,
                          output int lat, output logic [31:0] addr);
    bit seen;
    seen = 0;
    lat  = 0;
    addr = 32'h0;
    @(negedge clk);
    fetch_stage = 1'b1;
    if (load_at == 0) begin
      pc_load   = 1'b1;
      pc_target = tgt;
    end
    while (lat < 100) begin
      @(negedge clk);
      fetch_stage = 1'b0;
      pc_load     = 1'b0;
      lat++;
      if (mem_req && !seen) begin
        addr = mem_addr;
        seen = 1;
      end
      if (lat == load_at) begin
        pc_load   = 1'b1;
        pc_target = tgt;
      end
      if (instr_valid) break;
    end
    chk("fetch_completes", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    fetch_stage = 1'b0;
    pc_load     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int          lat;
  logic [31:0] addr;
  logic [31:0] tmp;

  initial begin
    rst = 1'b0; fetch_stage = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req",     32'(mem_req),     32'd0);
    chk("rst_mem_addr",    mem_addr,         32'h0);
    chk("rst_instr",       instr,            32'h0000_0013);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc",          pc,               32'h0);
    chk("rst_fetch_err",   32'(fetch_err),   32'd0);
    rst = 1'b1;

    // Minimal-latency fetch
    ack_delay = 1; rdata_val = 32'h0000_0513;
    do_fetch(-1, 32'h0, lat, addr);
    chk("t1_latency",  32'(lat), 32'd3);
    chk("t1_addr",     addr,     32'h0);
    chk("t1_instr",    instr,    32'h0000_0513);
    chk("t1_pc",       pc,       32'h0);
    chk("t1_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    chk("t1_valid_pulse", 32'(instr_valid), 32'd0);

    // Back-to-back fetches with two wait cycles
    do_reset();
    ack_delay = 2;
    for (int k = 0; k < 3; k++) begin
      rdata_val = 32'h0000_1000 + 32'(k);
      do_fetch(-1, 32'h0, lat, addr);
      chk("t2_addr",    addr,     32'(4 * k));
      chk("t2_latency", 32'(lat), 32'd4);
      chk("t2_instr",   instr,    32'h0000_1000 + 32'(k));
    end

    // Redirect during WAIT applies to the following fetch
    do_reset();
    do_fetch(-1, 32'h0, lat, addr);
    do_fetch(2, 32'h0000_0100, lat, addr);
    chk("t3_addr",  addr,            32'h4);
    chk("t3_pc",    pc,              32'h4);
    chk("t3_err",   32'(fetch_err),  32'd0);
    do_fetch(-1, 32'h0, lat, addr);
    chk("t3_redir_addr", addr, 32'h100);
    chk("t3_redir_pc",   pc,   32'h100);

    // Misaligned redirect is flagged and aligned; same-cycle redirect is used at once
    @(negedge clk); pc_load = 1'b1; pc_target = 32'h0000_0102;
    @(negedge clk); pc_load = 1'b0;
    @(negedge clk);
    chk("t4_err", 32'(fetch_err), 32'd1);
    do_fetch(-1, 32'h0, lat, addr);
    chk("t4_addr",       addr,           32'h100);
    chk("t4_err_sticky", 32'(fetch_err), 32'd1);
    do_fetch(0, 32'h0000_0200, lat, addr);
    chk("t4_same_cycle", addr, 32'h200);

    // Ack on the last permitted cycle, then a true timeout
    do_reset();
    ack_delay = 16; rdata_val = 32'hABCD_0001;
    do_fetch(-1, 32'h0, lat, addr);
    chk("t5_late_latency", 32'(lat),       32'd18);
    chk("t5_late_instr",   instr,          32'hABCD_0001);
    chk("t5_late_err",     32'(fetch_err), 32'd0);
    ack_delay = -1;
    do_fetch(-1, 32'h0, lat, addr);
    chk("t5_to_addr",    addr,           32'h4);
    chk("t5_to_latency", 32'(lat),       32'd18);
    chk("t5_to_instr",   instr,          32'h0000_0013);
    chk("t5_to_err",     32'(fetch_err), 32'd1);
    chk("t5_to_req",     32'(mem_req),   32'd0);
    ack_delay = 1;
    do_fetch(-1, 32'h0, lat, addr);
    chk("t5_next_addr", addr, 32'h8);

    // Reset in WAIT, then a stray ack
    ack_delay = 5;
    @(negedge clk); fetch_stage = 1'b1;
    @(negedge clk); fetch_stage = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("t6_req",   32'(mem_req),     32'd0);
    chk("t6_instr", instr,            32'h0000_0013);
    chk("t6_pc",    pc,               32'h0);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1; stray_ack = 1'b1;
    @(negedge clk);
    @(negedge clk); stray_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_valid", 32'(instr_valid), 32'd0);
    end

    // PC wrap
    ack_delay = 1;
    do_fetch(0, 32'hFFFF_FFFC, lat, addr);
    chk("t7_addr",     addr,     32'hFFFF_FFFC);
    chk("t7_pc_plus4", pc_plus4, 32'h0);
    do_fetch(-1, 32'h0, lat, addr);
    chk("t7_wrap_addr", addr, 32'h0);

    // Randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      fetch_stage = ($urandom % 3) == 0;
      pc_load     = ($urandom % 12) == 0;
      tmp         = $urandom;
      pc_target   = ($urandom % 8 == 0) ? tmp : (tmp & 32'hFFFF_FFFC);
      rst         = ($urandom % 600) != 0;
    end
    @(negedge clk);
    rand_mode = 0; fetch_stage = 1'b0; pc_load = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
